// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing helpers
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4,
    WAIT_IDLE  = 3'd5
  } rx_state_e;

  function automatic int calc_bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half_period(input int clk_freq, input int baud_rate);
    return calc_bit_period(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// load RESET_VAL while reset is high so the output never glitches out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity_err.
// Outputs data_valid/frame_err/parity_err are one-cycle pulses with no backpressure.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy,
  output rx_state_e  dbg_state_o
);

  localparam int BIT_PERIOD  = calc_bit_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = calc_half_period(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

  logic        rx_s;
  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q;
  logic        parity_err_q;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            cnt_q   <= 16'd0;
            state_q <= START_BIT;
          end
        end
        START_BIT: begin
          // Mid-start re-check: a high here was a line glitch, not a frame.
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            state_q   <= rx_s ? IDLE : DATA_BITS;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA_BITS: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q              <= 16'd0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY_BIT;
`else
              state_q <= STOP_BIT;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        PARITY_BIT: begin
`ifdef UART_RX_PARITY_EN
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= 16'd0;
            par_bad_q <= rx_s ^ (^shift_q);
            state_q   <= STOP_BIT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`else
          state_q <= IDLE;
`endif
        end
        STOP_BIT: begin
          // Leave at the stop midpoint so a start bit right after it is caught.
          if (cnt_q == BIT_LAST) begin
            cnt_q <= 16'd0;
            if (rx_s) begin
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad_q;
`endif
              state_q      <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign rx_busy     = (state_q != IDLE);
  assign dbg_state_o = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced bit period (100 clocks per bit).
// Covers 8N1 by default and 8E1 when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 100000;
  localparam int BAUD_RATE = 1000;
  localparam int BIT       = 100;
  localparam int HALF      = 50;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_PRE = 10;
`else
  localparam int FRAME_PRE = 9;
`endif
  // Start edge to data_valid: start..stop midpoint plus the 2-flop synchronizer.
  localparam int EXP_LAT = FRAME_PRE * BIT + HALF + 2;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;
  rx_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int dv_cyc = 0;
  logic dv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         gap;
    logic [7:0] exp_out;
    int         exp_dv;
    int         exp_fe;
  } vec_t;
  vec_t vecs[7];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .rx_busy     (rx_busy),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every data_valid must match the head of exp_q ({parity_err, byte}).
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        dv_cnt++;
        dv_cyc = cyc;
        check("dv_single_cycle", {31'd0, dv_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          check("dv_unexpected", 32'd1, 32'd0);
        end else begin
          check("dv_data_parity", {23'd0, parity_err, data_out}, {23'd0, exp_q.pop_front()});
        end
      end
      if (parity_err) begin
        pe_cnt++;
        check("pe_with_dv", {31'd0, data_valid}, 32'd1);
      end
      if (frame_err) begin
        fe_cnt++;
        check("fe_single_cycle", {31'd0, fe_prev}, 32'd0);
      end
      dv_prev = data_valid;
      fe_prev = frame_err;
    end
  end

  // Driver tasks: every line change lands 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input int cycles);
    rx = b;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_data_bits(input logic [7:0] d, input logic par_flip);
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, BIT);
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input int stop_low, input logic par_flip);
`ifdef UART_RX_PARITY_EN
    if (stop_low == 0) exp_q.push_back({par_flip, d});
`else
    if (stop_low == 0) exp_q.push_back({1'b0, d});
`endif
    send_data_bits(d, par_flip);
    if (stop_low > 0) drive_bit(1'b0, stop_low * BIT);
    drive_bit(1'b1, BIT);
  endtask

  initial begin
    int dv0;
    int fe0;
    int start_cyc;
    int lat;
    logic [7:0] last_good;

    vecs[0] = '{8'h55, 0, 100, 8'h55, 1, 0};
    vecs[1] = '{8'h00, 0,   0, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 0, 100, 8'hFF, 1, 0};
    vecs[3] = '{8'hA3, 3, 100, 8'hFF, 0, 1};
    vecs[4] = '{8'h81, 0, 100, 8'h81, 1, 0};
    vecs[5] = '{8'h96, 2, 100, 8'h81, 0, 1};
    vecs[6] = '{8'h6E, 0, 100, 8'h6E, 1, 0};

    // Reset state
    reset = 1'b1;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    drive_bit(1'b1, 10);

    // 0x55 with latency measured from the start edge
    dv0 = dv_cnt;
    start_cyc = cyc;
    send_frame(8'h55, 0, 1'b0);
    lat = dv_cyc - start_cyc;
    check("lat_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("lat_window", {31'd0, (lat >= EXP_LAT && lat <= EXP_LAT + 4)}, 32'd1);
    check("lat_data_out", {24'd0, data_out}, 32'h55);
    drive_bit(1'b1, BIT);

    // Glitch shorter than half a bit: START_BIT entered, then abandoned
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    drive_bit(1'b0, 10);
    check("glitch_busy", {31'd0, rx_busy}, 32'd1);
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 2 * BIT);
    check("glitch_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_idle_busy", {31'd0, rx_busy}, 32'd0);
    check("glitch_idle_state", 32'(dbg_state), 32'(IDLE));

    // Table-driven frames
    for (int v = 0; v < 7; v++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[v].data, vecs[v].stop_low, 1'b0);
      if (vecs[v].gap > 0) drive_bit(1'b1, vecs[v].gap);
      check($sformatf("vec%0d_dv", v), 32'(dv_cnt - dv0), 32'(vecs[v].exp_dv));
      check($sformatf("vec%0d_fe", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_data_out", v), {24'd0, data_out}, {24'd0, vecs[v].exp_out});
    end
    last_good = 8'h6E;

    // 0xA3 with the stop bit held low for 3 bit periods
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_data_bits(8'hA3, 1'b0);
    drive_bit(1'b0, 2 * BIT);
    check("brk_fe_once", 32'(fe_cnt - fe0), 32'd1);
    check("brk_wait_state", 32'(dbg_state), 32'(WAIT_IDLE));
    drive_bit(1'b0, BIT);
    check("brk_still_waiting", 32'(dbg_state), 32'(WAIT_IDLE));
    check("brk_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("brk_data_kept", {24'd0, data_out}, {24'd0, last_good});
    drive_bit(1'b1, 5);
    check("brk_back_idle", 32'(dbg_state), 32'(IDLE));
    drive_bit(1'b1, BIT);

    // Reset during data bit 4 of 0x3C, then 0x81
    dv0 = dv_cnt;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(logic'((8'h3C >> i) & 8'h01), BIT);
    drive_bit(1'b1, HALF);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_data_out", {24'd0, data_out}, 32'd0);
    check("midrst_busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;
    drive_bit(1'b1, BIT);
    check("midrst_no_dv", 32'(dv_cnt - dv0), 32'd0);
    send_frame(8'h81, 0, 1'b0);
    drive_bit(1'b1, BIT);
    check("midrst_one_dv", 32'(dv_cnt - dv0), 32'd1);
    check("midrst_data_81", {24'd0, data_out}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight; a 0 parity bit must flag parity_err with data_valid
    dv0 = dv_cnt;
    send_frame(8'h07, 0, 1'b1);
    drive_bit(1'b1, BIT);
    check("par_dv", 32'(dv_cnt - dv0), 32'd1);
    check("par_data", {24'd0, data_out}, 32'h07);
    check("par_err_total", 32'(pe_cnt), 32'd1);
`else
    check("nopar_err_total", 32'(pe_cnt), 32'd0);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 1000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 1000, line baud rate.
REQ-003 The block SHALL have port clk, input, 1, system clock; all state advances on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1, asynchronous serial line that idles high.
REQ-006 The block SHALL have port data_out, output, 8, last correctly framed byte received.
REQ-007 The block SHALL have port data_valid, output, 1, one-cycle pulse when data_out is updated.
REQ-008 The block SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-009 The block SHALL have port parity_err, output, 1, one-cycle pulse when the parity check fails.
REQ-010 The block SHALL have port rx_busy, output, 1, high in every state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-012 BIT_PERIOD SHALL equal CLK_FREQ/BAUD_RATE (1000 at defaults), and HALF_PERIOD SHALL equal BIT_PERIOD/2.
REQ-013 The cycle counter SHALL be 16 bits wide and the bit index 3 bits wide.
REQ-014 The FSM SHALL have exactly these states: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, WAIT_IDLE.
REQ-015 IDLE: when rx_s is 0, the FSM SHALL clear the counter and go to START_BIT.
REQ-016 START_BIT: the FSM SHALL count to HALF_PERIOD-1 and then sample rx_s.
REQ-016a If that START_BIT sample is 0, the FSM SHALL clear the counter and the bit index and go to DATA_BITS.
REQ-016b If that START_BIT sample is 1, the FSM SHALL treat it as a glitch and return to IDLE with no output pulse.
REQ-017 DATA_BITS: the FSM SHALL count to BIT_PERIOD-1 and then sample rx_s into shift_reg[bit_index], LSB first.
REQ-017a After bit index 7, the FSM SHALL go to PARITY_BIT when parity is enabled, otherwise to STOP_BIT.
REQ-018 PARITY_BIT: the FSM SHALL count to BIT_PERIOD-1, sample rx_s, and compare it with the XOR of shift_reg (even parity).
REQ-019 STOP_BIT: the FSM SHALL count to BIT_PERIOD-1 and then sample rx_s.
REQ-019a If the STOP_BIT sample is 1, the block SHALL load data_out from shift_reg, pulse data_valid for one cycle and go to IDLE.
REQ-019b If the STOP_BIT sample is 0, the block SHALL pulse frame_err for one cycle, leave data_out unchanged, assert no data_valid, and go to WAIT_IDLE.
REQ-020 WAIT_IDLE (break or line stuck low): the FSM SHALL stay until rx_s is 1, then go to IDLE, so no false start is detected.
REQ-021 On a parity mismatch, parity_err SHALL pulse in the same cycle as data_valid, and the byte SHALL still be delivered.
REQ-022 data_valid SHALL assert on the cycle after the stop-bit midpoint sample.
REQ-023 The FSM SHALL return to IDLE at the stop-bit midpoint, so a start bit directly after the stop bit is accepted.
REQ-024 data_valid, frame_err and parity_err SHALL be single-cycle pulses that are never held.

Reset
REQ-025 While reset is high: state=IDLE, data_out=0, data_valid=0, frame_err=0, parity_err=0, rx_busy=0, counter=0, bit index=0, shift_reg=0, and both synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no pulse; reception SHALL restart at the next falling edge after reset is released.

Configuration
REQ-027 When macro UART_RX_PARITY_EN is defined, the frame SHALL be 1 start, 8 data, 1 even-parity and 1 stop bit, and parity_err SHALL be active.
REQ-028 When UART_RX_PARITY_EN is undefined, the frame SHALL be 8N1, the PARITY_BIT state SHALL never be entered, and parity_err SHALL be tied to 0.

Structure
REQ-029 Package uart_pkg SHALL hold the rx state enum and the BIT_PERIOD and HALF_PERIOD calculation functions, shared with the transmitter.
REQ-030 The synchronizer SHALL be a separate sub-module, uart_sync2, with a parameterised reset value.

Verification
REQ-031 Send 0x55 as 8N1 at defaults -> data_out=0x55 and one data_valid pulse about 9500 cycles after the start edge, plus 2 synchronizer cycles.
REQ-032 Drive rx low for 200 cycles and then high -> no data_valid or frame_err, and the FSM is back in IDLE.
REQ-033 Send 0xA3 with the stop bit held low for 3 bit periods -> one frame_err pulse, data_out unchanged, no new start until rx returns high.
REQ-034 Send 0x00 then 0xFF back-to-back with no idle gap -> two data_valid pulses with data_out 0x00 and then 0xFF.
REQ-035 Assert reset during data bit 4 of 0x3C, then send 0x81 -> only 0x81 is reported.
REQ-036 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> data_valid, data_out=0x07 and parity_err all in the same cycle.
